// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Each grant is held until packet end, the burst cap, or a stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               arb_busy
);

  localparam int unsigned IdxW   = $clog2(N_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned StallW = $clog2(STALL_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]     grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic                last_flag_q, last_flag_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     cand;
  logic [IdxW-1:0]     next_ptr;
  logic [7:0]          sel_byte;
  logic                accept;
  logic                release_grant;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign sel_byte = req_data[{grant_idx_q, 3'b000} +: 8];
  assign next_ptr = (grant_idx_q == IdxW'(N_REQ - 1)) ? '0 : grant_idx_q + IdxW'(1);
  assign accept   = (state_q == StSend) && req_valid[grant_idx_q] && !tx_busy;

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == StSend) begin
      req_ready[grant_idx_q] = accept;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    burst_cnt_d   = burst_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    last_flag_d   = last_flag_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    release_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          tx_data_d   = sel_byte;
          tx_start_d  = 1'b1;
          burst_cnt_d = burst_cnt_q + BurstW'(1);
          last_flag_d = req_last[grant_idx_q];
          stall_cnt_d = '0;
          state_d     = StWaitAck;
        end else if (!req_valid[grant_idx_q]) begin
          // Release on the idle cycle that brings the count to STALL_TIMEOUT-1.
          if (stall_cnt_q == StallW'(STALL_TIMEOUT - 2)) begin
            release_grant = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
          end
        end
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (last_flag_q || burst_cnt_q == BurstW'(MAX_BURST)) begin
            release_grant = 1'b1;
          end else begin
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (release_grant) begin
      grant_d     = '0;
      rr_ptr_d    = next_ptr;
      burst_cnt_d = '0;
      stall_cnt_d = '0;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
      last_flag_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      last_flag_q <= last_flag_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign arb_busy = (state_q != StIdle);

endmodule
